// File: rtl/fetch_if.sv
// fetch_if: redirect, I-memory and decode-side signals of the fetch/prefetch unit
interface fetch_if #(parameter int WIDTH = 16, parameter int DEPTH = 4);
   logic                    redirect_valid;
   logic [WIDTH-1:0]        redirect_pc;
   logic                    mem_read;
   logic [WIDTH-1:0]        mem_address;
   logic                    mem_resp;
   logic [WIDTH-1:0]        mem_rdata;
   logic                    id_valid;
   logic                    id_ready;
   logic [WIDTH-1:0]        id_instr;
   logic [WIDTH-1:0]        id_pc;
   logic [$clog2(DEPTH):0]  fifo_count;
   modport master (
      input  redirect_valid, redirect_pc, mem_resp, mem_rdata, id_ready,
      output mem_read, mem_address, id_valid, id_instr, id_pc, fifo_count
   );
   modport slave (
      output redirect_valid, redirect_pc, mem_resp, mem_rdata, id_ready,
      input  mem_read, mem_address, id_valid, id_instr, id_pc, fifo_count
   );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: LC-3b fetch front end, one outstanding I-read, DEPTH-entry prefetch FIFO.
// Optional same-cycle response bypass to decode when FETCH_BYPASS_EN is defined.
module fetch_prefetch_unit #(
   parameter int               WIDTH    = 16,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] PC_RESET = '0,
   parameter int               PC_INC   = 2
) (
   input logic      clk,
   input logic      rst_n,
   fetch_if.master  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;
   state_t           state;
   logic [WIDTH-1:0] fetch_pc, req_addr, next_addr;
   logic             rd_req;
   logic [WIDTH-1:0] instr_q [DEPTH];
   logic [WIDTH-1:0] pc_q    [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    count, post_cnt;
   logic             push, pop;
   assign next_addr = req_addr + WIDTH'(PC_INC);
   assign pop       = bus.id_ready && count != '0;
   assign post_cnt  = count + CW'(push) - CW'(pop);
`ifdef FETCH_BYPASS_EN
   logic byp;
   assign byp          = state == BUSY && bus.mem_resp && !bus.redirect_valid && count == '0;
   assign push         = state == BUSY && bus.mem_resp && !bus.redirect_valid && !(byp && bus.id_ready);
   assign bus.id_valid = byp || count != '0;
   assign bus.id_instr = byp ? bus.mem_rdata : instr_q[rd_ptr];
   assign bus.id_pc    = byp ? next_addr : pc_q[rd_ptr];
`else
   assign push         = state == BUSY && bus.mem_resp && !bus.redirect_valid;
   assign bus.id_valid = count != '0;
   assign bus.id_instr = instr_q[rd_ptr];
   assign bus.id_pc    = pc_q[rd_ptr];
`endif
   assign bus.mem_read    = rd_req;
   assign bus.mem_address = req_addr;
   assign bus.fifo_count  = count;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fetch_pc <= PC_RESET;
         req_addr <= '0;
         rd_req   <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (bus.redirect_valid) fetch_pc <= bus.redirect_pc;
               else if (count < FULL) begin
                  state    <= BUSY;
                  req_addr <= fetch_pc;
                  rd_req   <= 1'b1;
               end
            BUSY:
               if (bus.redirect_valid) begin
                  fetch_pc <= bus.redirect_pc;
                  state    <= bus.mem_resp ? IDLE : DISCARD;
                  rd_req   <= !bus.mem_resp;
               end else if (bus.mem_resp) begin
                  fetch_pc <= next_addr;
                  // chain straight into the next sequential read while room remains
                  if (post_cnt < FULL) req_addr <= next_addr;
                  else begin
                     state  <= IDLE;
                     rd_req <= 1'b0;
                  end
               end
            DISCARD: begin
               if (bus.redirect_valid) fetch_pc <= bus.redirect_pc;
               if (bus.mem_resp) begin
                  state  <= IDLE;
                  rd_req <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               rd_req <= 1'b0;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else if (bus.redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            instr_q[wr_ptr] <= bus.mem_rdata;
            pc_q[wr_ptr]    <= next_addr;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= post_cnt;
      end
   end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: queue-based reference model plus directed checks of the fetch front end
module tb_fetch_prefetch_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   fetch_if #(.WIDTH(16), .DEPTH(4)) b0 ();
   fetch_if #(.WIDTH(16), .DEPTH(4)) b1 ();
   fetch_prefetch_unit #(.WIDTH(16), .DEPTH(4), .PC_RESET(16'h0000), .PC_INC(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(b0.master));
   fetch_prefetch_unit #(.WIDTH(16), .DEPTH(4), .PC_RESET(16'hFFFE), .PC_INC(2)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .bus(b1.master));
   int tests = 0;
   int fails = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   typedef struct { logic [15:0] i; logic [15:0] p; } ent_t;
   ent_t        q[$];
   bit          m_out, m_drop;
   logic [15:0] m_addr, m_pc;
   int          n0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_out = 0; m_drop = 0; m_addr = 16'h0; m_pc = 16'h0;
      end else begin
         n0 = q.size();
         if (b0.redirect_valid) begin
            q.delete();
            m_pc = b0.redirect_pc;
            if (m_out) begin
               if (b0.mem_resp) begin m_out = 0; m_drop = 0; end
               else m_drop = 1;
            end
         end else begin
            if (b0.id_ready && n0 > 0) void'(q.pop_front());
            if (m_out && b0.mem_resp) begin
               if (m_drop) begin m_out = 0; m_drop = 0; end
               else begin
                  q.push_back('{i: b0.mem_rdata, p: m_addr + 16'd2});
                  m_pc = m_addr + 16'd2;
                  if (q.size() < 4) m_addr = m_pc;
                  else m_out = 0;
               end
            end else if (!m_out && n0 < 4) begin
               m_out = 1;
               m_addr = m_pc;
            end
         end
      end
   end
   bit          rec2 = 0, rec3 = 0, auto_resp = 0;
   logic [31:0] got[$];
   int          maxc = 0, nreads = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         chk("mem_read", 32'(b0.mem_read), 32'(m_out));
         if (m_out) chk("mem_address", 32'(b0.mem_address), 32'(m_addr));
         chk("fifo_count", 32'(b0.fifo_count), q.size());
         chk("id_valid", 32'(b0.id_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            chk("id_instr", 32'(b0.id_instr), 32'(q[0].i));
            chk("id_pc", 32'(b0.id_pc), 32'(q[0].p));
         end
         if (rec2 && b0.id_valid && b0.id_ready) got.push_back({b0.id_instr, b0.id_pc});
         if (rec2 && int'(b0.fifo_count) > maxc) maxc = int'(b0.fifo_count);
         if (rec3 && b0.mem_read && b0.mem_resp) nreads++;
      end
   end
   logic [15:0] wa[$], wp[$];
   always @(posedge clk) begin
      #2;
      b1.mem_resp  = b1.mem_read;
      b1.mem_rdata = 16'hA5A5;
   end
   always @(negedge clk) begin
      if (rst_n) begin
         if (b1.mem_read && b1.mem_resp && wa.size() < 2) wa.push_back(b1.mem_address);
         if (b1.id_valid && wp.size() < 2) wp.push_back(b1.id_pc);
      end
   end
   task automatic step();
      @(posedge clk);
      #2;
      if (auto_resp) begin
         b0.mem_resp  = b0.mem_read;
         b0.mem_rdata = 16'h1001 + (b0.mem_address >> 1);
      end
   endtask
   initial begin
      b0.redirect_valid = 0; b0.redirect_pc = 0; b0.mem_resp = 0; b0.mem_rdata = 0; b0.id_ready = 0;
      b1.redirect_valid = 0; b1.redirect_pc = 0; b1.mem_resp = 0; b1.mem_rdata = 0; b1.id_ready = 1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_mem_read", 32'(b0.mem_read), 0);
      chk("rst_mem_address", 32'(b0.mem_address), 0);
      chk("rst_id_valid", 32'(b0.id_valid), 0);
      chk("rst_id_instr", 32'(b0.id_instr), 0);
      chk("rst_id_pc", 32'(b0.id_pc), 0);
      chk("rst_fifo_count", 32'(b0.fifo_count), 0);
      rst_n = 1;
      step(); step();
      chk("release_read", 32'(b0.mem_read), 1);
      chk("release_addr", 32'(b0.mem_address), 0);
      b0.id_ready = 1; auto_resp = 1; rec2 = 1;
      repeat (12) step();
      rec2 = 0;
      chk("stream_n", 32'(got.size() >= 3), 1);
      chk("stream_0", got[0], 32'h1001_0002);
      chk("stream_1", got[1], 32'h1002_0004);
      chk("stream_2", got[2], 32'h1003_0006);
      chk("stream_maxcount", 32'(maxc <= 1), 1);
      b0.id_ready = 0;
      repeat (10) step();
      chk("full_count", 32'(b0.fifo_count), 4);
      chk("full_read", 32'(b0.mem_read), 0);
      rec3 = 1; nreads = 0;
      b0.id_ready = 1;
      step();
      b0.id_ready = 0;
      repeat (6) step();
      rec3 = 0;
      chk("refill_reads", nreads, 1);
      chk("refill_count", 32'(b0.fifo_count), 4);
      chk("refill_read", 32'(b0.mem_read), 0);
      auto_resp = 0; b0.mem_resp = 0;
      b0.id_ready = 1;
      step();
      b0.id_ready = 0;
      step(); step();
      chk("pre_rst_busy", 32'(b0.mem_read), 1);
      rst_n = 0;
      #1;
      chk("midrst_read", 32'(b0.mem_read), 0);
      chk("midrst_valid", 32'(b0.id_valid), 0);
      chk("midrst_count", 32'(b0.fifo_count), 0);
      b0.mem_resp = 1; b0.mem_rdata = 16'hDEAD;
      step();
      rst_n = 1;
      step();
      b0.mem_resp = 0;
      chk("late_resp_count", 32'(b0.fifo_count), 0);
      step();
      chk("rerelease_read", 32'(b0.mem_read), 1);
      chk("rerelease_addr", 32'(b0.mem_address), 0);
      b0.redirect_valid = 1; b0.redirect_pc = 16'h3000;
      step();
      b0.redirect_valid = 0;
      chk("discard_read", 32'(b0.mem_read), 1);
      chk("discard_addr_held", 32'(b0.mem_address), 0);
      b0.mem_resp = 1; b0.mem_rdata = 16'hBEEF;
      step();
      b0.mem_resp = 0;
      chk("discard_idle", 32'(b0.mem_read), 0);
      chk("discard_count", 32'(b0.fifo_count), 0);
      step();
      chk("redirect_read", 32'(b0.mem_read), 1);
      chk("redirect_addr", 32'(b0.mem_address), 32'h3000);
      auto_resp = 1;
      repeat (3) step();
      chk("pre_flush_count", 32'(b0.fifo_count), 2);
      auto_resp = 0;
      b0.mem_rdata = 16'hCAFE; b0.redirect_valid = 1; b0.redirect_pc = 16'h4000;
      step();
      b0.redirect_valid = 0; b0.mem_resp = 0;
      chk("flush_valid", 32'(b0.id_valid), 0);
      chk("flush_count", 32'(b0.fifo_count), 0);
      chk("flush_idle", 32'(b0.mem_read), 0);
      step();
      chk("flush_read", 32'(b0.mem_read), 1);
      chk("flush_addr", 32'(b0.mem_address), 32'h4000);
      auto_resp = 1; b0.id_ready = 1;
      repeat (8) step();
      chk("wrap_n_addr", wa.size(), 2);
      chk("wrap_n_pc", wp.size(), 2);
      chk("wrap_addr0", 32'(wa[0]), 32'hFFFE);
      chk("wrap_addr1", 32'(wa[1]), 32'h0000);
      chk("wrap_pc0", 32'(wp[0]), 32'h0000);
      chk("wrap_pc1", 32'(wp[1]), 32'h0002);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
